// File: rtl/fp16_class_arbiter.sv
// Two-port round-robin front end for a shared FP16 classifier, with a one-entry
// registered response stage and saturating per-class statistic counters.
module fp16_class_arbiter #(
  parameter int CNT_W = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic [15:0]      a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [15:0]      b_data,
  output logic             b_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_data,
  output logic [5:0]       rsp_class,
  input  logic             cnt_clear,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic             class_err
);

  localparam logic             ID_A    = 1'b0;
  localparam logic             ID_B    = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [15:0]      rsp_data_q, rsp_data_d;
  logic [5:0]       rsp_class_q, rsp_class_d;
  logic             last_q, last_d;
  logic             class_err_q, class_err_d;
  logic [CNT_W-1:0] cnt_q [6];
  logic [CNT_W-1:0] cnt_d [6];

  logic        adv;
  logic        grant_a, grant_b;
  logic        accept;
  logic [15:0] sel_data;
  logic [5:0]  sel_class;
  logic        sel_onehot;

  // On contention the requester that did not win last time is granted.
  assign adv     = !rsp_valid_q || rsp_ready;
  assign grant_a = a_valid && (!b_valid || last_q == ID_B);
  assign grant_b = b_valid && (!a_valid || last_q == ID_A);
  assign a_ready = adv && grant_a;
  assign b_ready = adv && grant_b;
  assign accept  = a_ready || b_ready;

  assign sel_data = grant_b ? b_data : a_data;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_class = 6'b000000;
    if (sel_data[14:10] == 5'h1f) begin
      if (sel_data[9:0] == 10'd0) sel_class[3] = 1'b1;
      else if (sel_data[9])       sel_class[4] = 1'b1;
      else                        sel_class[5] = 1'b1;
    end else if (sel_data[14:10] == 5'h00) begin
      if (sel_data[9:0] == 10'd0) sel_class[2] = 1'b1;
      else                        sel_class[1] = 1'b1;
    end else begin
      sel_class[0] = 1'b1;
    end
  end

  assign sel_onehot = (sel_class != 6'd0) && ((sel_class & (sel_class - 6'd1)) == 6'd0);

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_class_d = rsp_class_q;
    last_d      = last_q;
    class_err_d = class_err_q;
    if (adv) begin
      rsp_valid_d = accept;
    end
    if (accept) begin
      rsp_id_d    = grant_b ? ID_B : ID_A;
      rsp_data_d  = sel_data;
      rsp_class_d = sel_class;
      last_d      = grant_b ? ID_B : ID_A;
      class_err_d = class_err_q || !sel_onehot;
    end
  end

  // A clear beats a coincident accept; counters stick at all-ones instead of wrapping.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clear) begin
        cnt_d[i] = '0;
      end else if (accept && sel_class[i] && cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= ID_A;
      rsp_data_q  <= 16'd0;
      rsp_class_q <= 6'd0;
      last_q      <= ID_B;
      class_err_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_class_q <= rsp_class_d;
      last_q      <= last_d;
      class_err_q <= class_err_d;
    end
  end

  // NOTE: the counter array is reset like any other flop; it is six registers, not a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 6; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    cnt_out = '0;
    case (cnt_sel)
      3'd0:    cnt_out = cnt_q[0];
      3'd1:    cnt_out = cnt_q[1];
      3'd2:    cnt_out = cnt_q[2];
      3'd3:    cnt_out = cnt_q[3];
      3'd4:    cnt_out = cnt_q[4];
      3'd5:    cnt_out = cnt_q[5];
      default: cnt_out = '0;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_class = rsp_class_q;
  assign class_err = class_err_q;

endmodule

// File: tb/tb_fp16_class_arbiter.sv
// Bench for fp16_class_arbiter: directed scenarios plus randomized traffic, all
// compared against a transaction-level model; a CNT_W=4 copy exercises saturation.
`timescale 1ns/1ps
module tb_fp16_class_arbiter;

  localparam int SAT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, rsp_ready, cnt_clear;
  logic [15:0] a_data, b_data;
  logic [2:0]  cnt_sel;

  logic        a_ready, b_ready, rsp_valid, rsp_id, class_err;
  logic [15:0] rsp_data;
  logic [5:0]  rsp_class;
  logic [16:0] cnt_out;

  logic        s_a_ready, s_b_ready, s_rsp_valid, s_rsp_id, s_class_err;
  logic [15:0] s_rsp_data;
  logic [5:0]  s_rsp_class;
  logic [3:0]  s_cnt_out;

  fp16_class_arbiter #(.CNT_W(17)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_class(rsp_class),
    .cnt_clear(cnt_clear), .cnt_sel(cnt_sel), .cnt_out(cnt_out),
    .class_err(class_err)
  );

  fp16_class_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(s_a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(s_b_ready),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
    .rsp_data(s_rsp_data), .rsp_class(s_rsp_class),
    .cnt_clear(cnt_clear), .cnt_sel(cnt_sel), .cnt_out(s_cnt_out),
    .class_err(s_class_err)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: what the response slot holds, who won last, and
  // how many items of each class were accepted since the last clear.
  logic        m_valid;
  logic        m_id;
  logic [15:0] m_data;
  logic [5:0]  m_class;
  logic        m_last_b;
  int          m_cnt [6];

  logic smp_a_ready, smp_b_ready;
  logic [5:0] smp_class;

  function automatic logic [5:0] ref_class(input logic [15:0] d);
    int mag;
    mag = int'(d) % 32768;
    if (mag == 0)           return 6'b000100;
    else if (mag < 1024)    return 6'b000010;
    else if (mag < 31744)   return 6'b000001;
    else if (mag == 31744)  return 6'b001000;
    else if (mag >= 32256)  return 6'b010000;
    else                    return 6'b100000;
  endfunction

  function automatic int bit_index(input logic [5:0] c);
    for (int i = 0; i < 6; i++) if (c == (6'b1 << i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_id     = 1'b0;
    m_data   = 16'd0;
    m_class  = 6'd0;
    m_last_b = 1'b1;
    for (int i = 0; i < 6; i++) m_cnt[i] = 0;
  endtask

  function automatic int exp_cnt(input int sel, input int cap);
    if (sel > 5) return 0;
    return (m_cnt[sel] > cap) ? cap : m_cnt[sel];
  endfunction

  // One clock: inputs applied, outputs compared to the model mid-cycle, model advanced at the edge.
  task automatic cycle(input logic av, input logic [15:0] ad, input logic bv,
                       input logic [15:0] bd, input logic rr, input logic clr);
    logic room, exp_a, exp_b;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    rsp_ready = rr; cnt_clear = clr;
    @(negedge clk);
    room  = !m_valid || rr;
    exp_a = room && av && (!bv || m_last_b);
    exp_b = room && bv && (!av || !m_last_b);
    smp_a_ready = a_ready;
    smp_b_ready = b_ready;
    smp_class   = rsp_class;
    check("a_ready", a_ready, exp_a);
    check("b_ready", b_ready, exp_b);
    check("rsp_valid", rsp_valid, m_valid);
    check("sat_a_ready", s_a_ready, exp_a);
    check("sat_b_ready", s_b_ready, exp_b);
    check("sat_rsp_valid", s_rsp_valid, m_valid);
    if (m_valid) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_data", rsp_data, m_data);
      check("rsp_class", rsp_class, m_class);
      check("sat_rsp_fields", {s_rsp_id, s_rsp_data, s_rsp_class}, {m_id, m_data, m_class});
    end
    check("cnt_out", cnt_out, exp_cnt(int'(cnt_sel), 131071));
    check("sat_cnt_out", s_cnt_out, exp_cnt(int'(cnt_sel), SAT_MAX));
    check("class_err", {class_err, s_class_err}, 2'b00);
    @(posedge clk);
    if (exp_a || exp_b) begin
      m_valid  = 1'b1;
      m_id     = exp_b;
      m_data   = exp_b ? bd : ad;
      m_class  = ref_class(m_data);
      m_last_b = exp_b;
      if (!clr) m_cnt[bit_index(m_class)]++;
    end else if (room) begin
      m_valid = 1'b0;
    end
    if (clr) for (int i = 0; i < 6; i++) m_cnt[i] = 0;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b0);
  endtask

  // Absolute counter readout against numbers fixed by the scenario, both widths.
  task automatic check_counts(input string tag, input int n0, input int n1, input int n2,
                              input int n3, input int n4, input int n5);
    int e [6];
    logic [2:0] keep;
    e[0] = n0; e[1] = n1; e[2] = n2; e[3] = n3; e[4] = n4; e[5] = n5;
    keep = cnt_sel;
    for (int s = 0; s < 8; s++) begin
      cnt_sel = 3'(s);
      #1;
      check($sformatf("%s_cnt%0d", tag, s), cnt_out, (s < 6) ? e[s] : 0);
      check($sformatf("%s_satcnt%0d", tag, s), s_cnt_out,
            (s < 6) ? ((e[s] > SAT_MAX) ? SAT_MAX : e[s]) : 0);
    end
    cnt_sel = keep;
  endtask

  function automatic logic [15:0] rand_fp();
    case ($urandom_range(0, 7))
      0: return 16'h7C00 | (16'($urandom_range(0, 1)) << 15);
      1: return 16'h7E00 | 16'($urandom_range(0, 511));
      2: return 16'h7C01 + 16'($urandom_range(0, 510));
      3: return 16'($urandom_range(0, 1)) << 15;
      4: return 16'($urandom_range(1, 1023));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic av, bv;
    logic [15:0] ad, bd;

    reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_data = 16'd0; b_data = 16'd0;
    rsp_ready = 1'b1; cnt_clear = 1'b0; cnt_sel = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_fields", {rsp_id, rsp_data, rsp_class}, 23'd0);
    check("reset_class_err", class_err, 1'b0);
    reset = 1'b0;
    check_counts("reset", 0, 0, 0, 0, 0, 0);

    // Contention straight out of reset: A first, then alternate.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'h3C00 + 16'(i), 1'b1, 16'hBC00 + 16'(i), 1'b1, 1'b0);
      check("contend_grant_a", smp_a_ready, (i % 2) == 0);
    end
    idle(1);

    // Exhaustive sweep from requester A.
    cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < 65536; i++) cycle(1'b1, 16'(i), 1'b0, 16'd0, 1'b1, 1'b0);
    idle(1);
    check_counts("sweep", 61440, 2046, 2, 2, 1024, 1022);

    // Saturation at CNT_W = 4.
    cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 16'h3C00, 1'b0, 16'd0, 1'b1, 1'b0);
    idle(2);
    check_counts("sat", 20, 0, 0, 0, 0, 0);

    // Backpressure: hold an inf result, then release into a qnan.
    cycle(1'b1, 16'h7C00, 1'b0, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h7E00, 1'b0, 16'd0, 1'b0, 1'b0);
      check("bp_hold_class", smp_class, 6'b001000);
      check("bp_hold_ready", {smp_a_ready, smp_b_ready}, 2'b00);
    end
    cycle(1'b1, 16'h7E00, 1'b0, 16'd0, 1'b1, 1'b0);
    check("bp_release_accept", smp_a_ready, 1'b1);
    idle(1);
    check("bp_release_class", smp_class, 6'b010000);

    // Clear colliding with an accept.
    cycle(1'b1, 16'h0001, 1'b0, 16'd0, 1'b1, 1'b1);
    idle(1);
    check("clr_rsp_class", smp_class, 6'b000010);
    check_counts("clr", 0, 0, 0, 0, 0, 0);

    // Randomized traffic honouring the hold-while-waiting rule.
    av = 1'b0; bv = 1'b0; ad = 16'd0; bd = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!(av && !smp_a_ready)) begin
        av = ($urandom_range(0, 3) != 0);
        ad = rand_fp();
      end
      if (!(bv && !smp_b_ready)) begin
        bv = ($urandom_range(0, 3) != 0);
        bd = rand_fp();
      end
      cnt_sel = 3'($urandom_range(0, 7));
      cycle(av, ad, bv, bd, $urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    end
    cnt_sel = 3'd0;
    idle(2);

    // Reset while a response is stalled.
    cycle(1'b1, 16'h3C00, 1'b0, 16'd0, 1'b1, 1'b0);
    cycle(1'b0, 16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    rsp_ready = 1'b0;
    check("pre_reset_valid", rsp_valid, 1'b1);
    reset = 1'b1;
    #1;
    check("midreset_rsp_valid", {rsp_valid, s_rsp_valid}, 2'b00);
    check_counts("midreset", 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h4000, 1'b1, 16'h0000, 1'b1, 1'b0);
      check("postreset_grant_a", smp_a_ready, (i % 2) == 0);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp16_class_arbiter.md
# fp16_class_arbiter

Shares one half-precision classifier (Fp_clasifier, 16-bit input, six one-hot class flags) between two requesters. Round-robin arbitration, valid/ready handshakes on both request ports, a one-entry registered response stage, and per-class statistic counters readable through a select port. Sits in front of the FP16 datapath, where operands are tagged by class before dispatch.

## Interface

- CNT_W, 17, width of each per-class counter; must be ≥2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A has an operand.
- a_data  in  16  requester A FP16 operand.
- a_ready  out  1  requester A operand accepted this cycle.
- b_valid  in  1  requester B has an operand.
- b_data  in  16  requester B FP16 operand.
- b_ready  out  1  requester B operand accepted this cycle.
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer takes the response.
- rsp_id  out  1  source of the response: 0 = A, 1 = B.
- rsp_data  out  16  operand echoed.
- rsp_class  out  6  {snan, qnan, inf, zero, subnormal, normal}, one-hot.
- cnt_clear  in  1  synchronous clear of all counters.
- cnt_sel  in  3  counter select: 0 = normal … 5 = snan (the rsp_class bit index); 6 and 7 select nothing.
- cnt_out  out  CNT_W  selected counter, combinational from registers; 0 for cnt_sel 6/7.
- class_err  out  1  sticky: the classifier produced a non-one-hot vector.

## Operation

- Classification, with exp = d[14:10] and frac = d[9:0]:
  - exp = 31: frac = 0 is inf; frac[9] = 1 is qnan; otherwise snan.
  - exp = 0: frac = 0 is zero; otherwise subnormal.
  - Any other exp is normal.
  - Sign is ignored.
- Advance condition: adv = !rsp_valid | rsp_ready.
- Arbiter:
  - Only one valid requester: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - Pointer `last` updates only on an accepted grant.
  - Reset value of `last` is B, so A wins the first contention.
- a_ready = adv & grant_A; b_ready = adv & grant_B. Both are combinational and are never asserted together.
- Accept (x_valid & x_ready):
  - Registers {id, data, class} into the response stage.
  - Sets rsp_valid.
  - Increments the counter for that class.
- adv with no accept: rsp_valid clears when rsp_ready empties the stage.
- Counters:
  - Saturate at 2^CNT_W − 1 and never wrap.
  - cnt_clear zeroes all six counters.
  - cnt_clear in the same cycle as an accept: the clear wins and the item is not counted. The response is still produced.
- class_err:
  - Sets on any accept whose class vector is not one-hot.
  - Cleared only by reset.
- Reset clears these outputs and registers to 0: rsp_valid, rsp_id, rsp_data, rsp_class, all counters, class_err. `last` resets to B.
- Reset mid-transfer drops the held response.

## Timing

- Latency: accept in cycle N gives rsp_valid = 1 with the result in cycle N+1.
- Throughput: one operand per cycle while rsp_ready = 1.
- Backpressure:
  - rsp_valid = 1 and rsp_ready = 0 hold all rsp_* stable.
  - a_ready and b_ready stay 0 during the hold.
- Requesters must hold data stable while valid and not ready. This is not checked.
- Counter update is visible on cnt_out the cycle after the accept.
- cnt_clear takes effect on cnt_out the next cycle.

## Test plan

- Sweep: A presents 0x0000…0xFFFF back-to-back, rsp_ready = 1, B idle. Required results:
  - Counters: snan 1022, qnan 1024, inf 2, zero 2, subnormal 2046, normal 61440.
  - Counter sum 65536; class_err = 0.
  - Every rsp_id = 0 and rsp_data equals the input sequence.
- Contention: a_valid = b_valid = 1 for 8 cycles after reset, rsp_ready = 1.
  - Grants go A, B, A, B, …
  - rsp_id sequence is 0, 1, 0, 1, … starting the cycle after the first accept.
- Backpressure:
  - Accept 0x7C00, then rsp_ready = 0 for 3 cycles. rsp_class = 6'b001000 is held, and a_ready = b_ready = 0 throughout.
  - Raise rsp_ready: the next operand (0x7E00) accepts in the same cycle and yields rsp_class = 6'b010000.
- Saturation: CNT_W = 4, send 20 × 0x3C00.
  - normal counter reads 15 and holds there.
  - All other counters read 0.
- Clear collision: assert cnt_clear in the same cycle A is accepted with 0x0001.
  - All counters read 0 next cycle.
  - rsp_class = 6'b000010 is still produced.
- Reset mid-operation: assert reset while rsp_valid = 1 and rsp_ready = 0.
  - rsp_valid and counters go to 0 immediately.
  - After release, the first contention is granted to A.
